// File: rtl/layer_line_scanout_pkg.sv
// ============================================================================
// layer_line_scanout_pkg : shared state encoding and line-buffer constants
// Rev 1.0
// ============================================================================
`default_nettype none

package layer_line_scanout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } scan_state_e;

  localparam int LINEBUF_PIXELS = 768;
  localparam int HSCALE_ONE     = 128;
  localparam int FRAC_BITS      = 7;
  localparam int POS_W          = 10 + FRAC_BITS;

  function automatic logic idx_in_linebuf(input logic [9:0] idx);
    return int'(idx) < LINEBUF_PIXELS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scanout_skid_fifo.sv
// ============================================================================
// scanout_skid_fifo : 2-entry first-word-fall-through pixel buffer with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module scanout_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_pop;

  // The head entry never moves while held, so data_o is stable under stall.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_line_scanout.sv
// ============================================================================
// layer_line_scanout : scaled horizontal scanout of one line-buffer line
// Optional build macro: SCANOUT_RANGE_CLAMP_EN (zero pixels read past 767)
// Rev 1.0
// ============================================================================
`default_nettype none

module layer_line_scanout
  import layer_line_scanout_pkg::*;
#(
  parameter int OUT_W_MAX = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [9:0] hstart,
  input  logic [7:0] hscale,
  input  logic [9:0] out_width,
  output logic       active_render_buffer,
  output logic [9:0] composer_rd_idx,
  input  logic [7:0] composer_rd_data,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy,
  output logic       line_done
);

`ifdef SCANOUT_RANGE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [9:0] WMAX = 10'(OUT_W_MAX);

  scan_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [9:0]       left_q, left_d;
  logic             arb_q;
  logic             inflight_q;
  logic             oob_q;

  logic [9:0]       width_eff;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic             pop;
  logic             push;
  logic             issue;
  logic             last_accept;
  logic             zero_done;
  logic [7:0]       push_data;

  assign width_eff       = (out_width > WMAX) ? WMAX : out_width;
  assign composer_rd_idx = pos_q[POS_W-1:FRAC_BITS];

  // A restart flushes, so nothing is popped or pushed in that cycle.
  assign pop       = pix_valid && pix_ready && !line_start;
  assign push      = inflight_q && !line_start;
  assign occupancy = {2'b00, inflight_q} + {1'b0, fifo_count} - {2'b00, pop};
  assign issue     = (state_q == ST_ACTIVE) && (left_q != 10'd0) &&
                     (occupancy < 3'd2) && !line_start;

  assign last_accept = (state_q == ST_DRAIN) && !inflight_q &&
                       (fifo_count == 2'd1) && pop;
  assign zero_done   = (state_q == ST_ACTIVE) && (left_q == 10'd0) && !line_start;

  assign push_data = (CLAMP_EN && oob_q) ? 8'h00 : composer_rd_data;

  assign active_render_buffer = arb_q;
  assign busy                 = (state_q != ST_IDLE);
  assign line_done            = last_accept || zero_done;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    left_d  = left_q;
    if (line_start) begin
      state_d = ST_ACTIVE;
      pos_d   = {hstart, {FRAC_BITS{1'b0}}};
      left_d  = width_eff;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (left_q == 10'd0) begin
            state_d = ST_IDLE;
          end else if (issue) begin
            pos_d  = pos_q + {{(POS_W-8){1'b0}}, hscale};
            left_d = left_q - 10'd1;
            if (left_q == 10'd1) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_accept) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      left_q     <= '0;
      arb_q      <= 1'b0;
      inflight_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      left_q     <= left_d;
      arb_q      <= arb_q ^ line_start;
      inflight_q <= issue;
      oob_q      <= !idx_in_linebuf(composer_rd_idx);
    end
  end

  scanout_skid_fifo #(
    .DATA_W (8)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (line_start),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .data_o      (pix_data),
    .valid_o     (pix_valid),
    .count_o     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_layer_line_scanout.sv
// ============================================================================
// tb_layer_line_scanout : directed bench with a line-level reference model
// Honours SCANOUT_RANGE_CLAMP_EN when the DUT is built with it.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_layer_line_scanout;
  import layer_line_scanout_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] hstart = '0;
  logic [7:0] hscale = '0;
  logic [9:0] out_width = '0;
  logic       active_render_buffer;
  logic [9:0] composer_rd_idx;
  logic [7:0] composer_rd_data = '0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b1;
  logic       busy;
  logic       line_done;

  layer_line_scanout #(.OUT_W_MAX(800)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .line_start           (line_start),
    .hstart               (hstart),
    .hscale               (hscale),
    .out_width            (out_width),
    .active_render_buffer (active_render_buffer),
    .composer_rd_idx      (composer_rd_idx),
    .composer_rd_data     (composer_rd_data),
    .pix_data             (pix_data),
    .pix_valid            (pix_valid),
    .pix_ready            (pix_ready),
    .busy                 (busy),
    .line_done            (line_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) composer_rd_data <= mem[composer_rd_idx];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Source index of output pixel k: hstart + k*hscale/128, with the 17-bit position wrapping.
  function automatic int exp_idx(input int hs, input int sc, input int k);
    return ((hs * HSCALE_ONE + k * sc) % (1 << POS_W)) >> FRAC_BITS;
  endfunction

  function automatic logic [7:0] exp_pix(input int hs, input int sc, input int k);
    int idx;
    idx = exp_idx(hs, sc, k);
`ifdef SCANOUT_RANGE_CLAMP_EN
    if (idx >= LINEBUF_PIXELS) return 8'h00;
`endif
    return mem[idx];
  endfunction

  // ---------------- reference model and per-cycle compare ----------------
  logic [7:0] exp_q[$];
  logic       m_arb = 1'b0;
  logic       m_busy = 1'b0;
  logic       zw = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       exp_done;
  int         n_done = 0;
  int         n_acc_line = 0;
  logic [7:0] log_px [1024];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_arb = 1'b0; m_busy = 1'b0; zw = 1'b0; prev_stall = 1'b0; n_acc_line = 0;
      end else begin
        chk("active_render_buffer", int'(active_render_buffer), int'(m_arb));
        chk("busy", int'(busy), int'(m_busy));
        exp_done = zw;
        zw = 1'b0;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_pixel", $sformatf("got pixel 0x%0h, required none", pix_data));
          end else begin
            chk("pix_data", int'(pix_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
            if (n_acc_line < 1024) log_px[n_acc_line] = pix_data;
            n_acc_line++;
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
        if (line_start) exp_done = 1'b0;
        chk("line_done", int'(line_done), int'(exp_done));
        if (line_done) n_done++;
        if (exp_done) m_busy = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", int'(pix_valid), 1);
          chk("stall_data", int'(pix_data), int'(prev_data));
        end
        prev_stall = pix_valid && !pix_ready && !line_start;
        prev_data  = pix_data;
        if (line_start) begin
          m_arb = ~m_arb;
          exp_q.delete();
          for (int k = 0; k < int'(out_width); k++)
            exp_q.push_back(exp_pix(int'(hstart), int'(hscale), k));
          m_busy = 1'b1;
          zw = (out_width == 10'd0);
          n_acc_line = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_line(input int hs, input int sc, input int w);
    @(posedge clk); #1;
    hstart = 10'(hs); hscale = 8'(sc); out_width = 10'(w); line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit rnd_ready);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      if (rnd_ready) pix_ready = 1'($urandom_range(0, 1));
      n++;
    end
    pix_ready = 1'b1;
    if (busy) fail_now(name, "line did not complete within 5000 cycles");
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_all_pixels"}, exp_q.size(), 0);
  endtask

  int t2_idx [8] = '{10, 10, 11, 11, 12, 12, 13, 13};
  int t5_idx [6] = '{1020, 1021, 1022, 1023, 0, 1};
  int done0;
  logic arb0;
  int n;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arb", int'(active_render_buffer), 0);
    chk("rst_rd_idx", int'(composer_rd_idx), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_line_done", int'(line_done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1:1 scan of 640 pixels, full throughput
    done0 = n_done;
    start_line(0, HSCALE_ONE, 640);
    for (int k = 1; k <= 640; k++) begin
      @(negedge clk);
      chk("t1_rd_idx", int'(composer_rd_idx), k - 1);
      if (k == 1) chk("t1_valid_e1", int'(pix_valid), 0);
      if (k == 2) chk("t1_valid_e1b", int'(pix_valid), 0);
      if (k == 3) chk("t1_first_valid", int'(pix_valid), 1);
      if (k == 3) chk("t1_first_pix", int'(pix_data), int'(mem[0]));
    end
    wait_idle("t1", 1'b0);
    chk("t1_line_done_count", n_done - done0, 1);
    chk("t1_pixels", n_acc_line, 640);

    // Half-step upscale
    start_line(10, 64, 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_model_idx", exp_idx(10, 64, k), t2_idx[k]);
      chk("t2_rd_idx", int'(composer_rd_idx), t2_idx[k]);
    end
    wait_idle("t2", 1'b0);
    chk("t2_pix3", int'(log_px[3]), int'(mem[11]));

    // Random backpressure
    done0 = n_done;
    start_line(5, 200, 100);
    wait_idle("t3", 1'b1);
    chk("t3_pixels", n_acc_line, 100);
    chk("t3_line_done_count", n_done - done0, 1);

    // Restart mid-line
    done0 = n_done;
    arb0 = active_render_buffer;
    start_line(100, HSCALE_ONE, 80);
    n = 0;
    while (n_acc_line < 37 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_acc_line < 37) fail_now("t4_wait", "pixel 37 never reached");
    chk("t4_no_done_first", n_done - done0, 0);
    start_line(300, HSCALE_ONE, 20);
    @(negedge clk);
    chk("t4_new_hstart", int'(composer_rd_idx), 300);
    wait_idle("t4", 1'b0);
    chk("t4_arb_twice", int'(active_render_buffer), int'(arb0));
    chk("t4_line_done_count", n_done - done0, 1);
    chk("t4_pixels", n_acc_line, 20);
    chk("t4_first_pix", int'(log_px[0]), int'(mem[300]));

    // Index wrap at 1023
    mem[1020] = 8'hA5; mem[1021] = 8'hA6; mem[1022] = 8'hA7; mem[1023] = 8'hA8;
    mem[0] = 8'h11; mem[1] = 8'h22;
    start_line(1020, HSCALE_ONE, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_model_idx", exp_idx(1020, HSCALE_ONE, k), t5_idx[k]);
      chk("t5_rd_idx", int'(composer_rd_idx), t5_idx[k]);
    end
    wait_idle("t5", 1'b0);
`ifdef SCANOUT_RANGE_CLAMP_EN
    chk("t5_pix0", int'(log_px[0]), 8'h00);
    chk("t5_pix3", int'(log_px[3]), 8'h00);
`else
    chk("t5_pix0", int'(log_px[0]), 8'hA5);
    chk("t5_pix3", int'(log_px[3]), 8'hA8);
`endif
    chk("t5_pix4", int'(log_px[4]), 8'h11);
    chk("t5_pix5", int'(log_px[5]), 8'h22);

    // hscale = 0 repeats hstart
    start_line(77, 0, 5);
    wait_idle("t6a", 1'b0);
    chk("t6a_pix4", int'(log_px[4]), int'(mem[77]));

    // Zero-width line
    done0 = n_done;
    start_line(5, HSCALE_ONE, 0);
    @(negedge clk);
    chk("t6_zero_done", int'(line_done), 1);
    chk("t6_zero_valid", int'(pix_valid), 0);
    @(negedge clk);
    chk("t6_zero_done_once", int'(line_done), 0);
    chk("t6_zero_idle", int'(busy), 0);
    chk("t6_zero_count", n_done - done0, 1);

    // Asynchronous reset mid-line
    start_line(50, HSCALE_ONE, 50);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_arb", int'(active_render_buffer), 0);
    chk("t7_rd_idx", int'(composer_rd_idx), 0);
    chk("t7_pix_data", int'(pix_data), 0);
    chk("t7_pix_valid", int'(pix_valid), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_line_done", int'(line_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t7_no_pixel", int'(pix_valid), 0);
    end
    start_line(7, HSCALE_ONE, 5);
    wait_idle("t7_recover", 1'b0);
    chk("t7_recover_pixels", n_acc_line, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
